// File: rtl/event_accumulator.sv
// event_accumulator
// Captures DEPTH-sample records on each trigger, sums N such events
// point-by-point into an on-chip memory, then drains the summed record
// (optionally right-shifted for averaging) over a valid/ready handshake.
// Optional build macro: EVENT_ACC_SATURATE_EN. When it is defined, an
// overflowing sum stores all-ones. Without it, the sum wraps.
// The sticky overflow flag is set in both builds.

module event_accumulator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] inputData,
    input  logic              dataCaptureStrobe,
    input  logic [7:0]        numEventsToAdd,
    input  logic [3:0]        avgShift,
    input  logic              readyToTransmit,
    output logic [ACC_W-1:0]  dataOut,
    output logic              dataValid,
    output logic              busy,
    output logic [7:0]        eventCount,
    output logic              overflow,
    output logic [7:0]        droppedTrig
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [3:0] ST_ARMED   = 4'b0001;
    localparam logic [3:0] ST_CAPTURE = 4'b0010;
    localparam logic [3:0] ST_CHECK   = 4'b0100;
    localparam logic [3:0] ST_DRAIN   = 4'b1000;

    logic [3:0]       state;
    logic [ACC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    cap_addr;
    logic [AW:0]      rd_addr;     // MSB set once every word has been fetched
    logic [AW-1:0]    xfer_cnt;
    logic [7:0]       n_latched;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] sum_store;
    logic [ACC_W-1:0] rd_word;
    logic [ACC_W-1:0] rd_shifted;
    logic             load_word;
    logic             xfer;

    assign busy      = (state != ST_ARMED);
    assign xfer      = dataValid & readyToTransmit;
    // Refill the output register when it is empty or being emptied this cycle.
    assign load_word = (state == ST_DRAIN) && !rd_addr[AW] && (!dataValid || readyToTransmit);

    // Accumulate the incoming sample into the addressed word, one carry bit wide.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        sum_wide = {1'b0, mem[cap_addr]} + (ACC_W+1)'(inputData);
        if (eventCount == 8'd0) begin
            // First event overwrites, so the memory never needs clearing.
            sum_wide = (ACC_W+1)'(inputData);
        end
        sum_store = sum_wide[ACC_W-1:0];
`ifdef EVENT_ACC_SATURATE_EN
        if (sum_wide[ACC_W]) begin
            sum_store = '1;
        end
`else
        // Wrap modulo 2^ACC_W: keep the low bits as they are.
`endif
    end

    // Fetch the next drain word and apply the per-word logical right shift.
    always_comb begin
        rd_word    = mem[rd_addr[AW-1:0]];
        rd_shifted = (int'(avgShift) >= ACC_W) ? '0 : (rd_word >> avgShift);
    end

    // Record memory: written only while capturing.
    // NOTE: the memory has no reset; the first-event overwrite makes old contents irrelevant.
    always_ff @(posedge clk) begin
        if (state == ST_CAPTURE) begin
            mem[cap_addr] <= sum_store;
        end
    end

    // Control FSM, counters, status flags and the drain output register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_ARMED;
            eventCount  <= 8'd0;
            dataValid   <= 1'b0;
            dataOut     <= '0;
            overflow    <= 1'b0;
            droppedTrig <= 8'd0;
            cap_addr    <= '0;
            rd_addr     <= '0;
            xfer_cnt    <= '0;
            n_latched   <= 8'd1;
        end else begin
            // Triggers arriving while busy are counted, not honoured.
            if (dataCaptureStrobe && (state != ST_ARMED) && (droppedTrig != 8'hFF)) begin
                droppedTrig <= droppedTrig + 8'd1;
            end

            case (state)
                ST_ARMED: begin
                    if (dataCaptureStrobe) begin
                        state    <= ST_CAPTURE;
                        cap_addr <= '0;
                        if (eventCount == 8'd0) begin
                            n_latched <= (numEventsToAdd == 8'd0) ? 8'd1 : numEventsToAdd;
                        end
                    end
                end

                ST_CAPTURE: begin
                    if (sum_wide[ACC_W]) begin
                        overflow <= 1'b1;
                    end
                    cap_addr <= cap_addr + 1'b1;
                    if (cap_addr == AW'(DEPTH - 1)) begin
                        state <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    eventCount <= eventCount + 8'd1;
                    rd_addr    <= '0;
                    xfer_cnt   <= '0;
                    dataValid  <= 1'b0;
                    state      <= ((eventCount + 8'd1) == n_latched) ? ST_DRAIN : ST_ARMED;
                end

                ST_DRAIN: begin
                    if (load_word) begin
                        dataOut   <= rd_shifted;
                        dataValid <= 1'b1;
                        rd_addr   <= rd_addr + 1'b1;
                    end else if (xfer) begin
                        dataValid <= 1'b0;
                    end
                    if (xfer) begin
                        xfer_cnt <= xfer_cnt + 1'b1;
                        if (xfer_cnt == AW'(DEPTH - 1)) begin
                            state      <= ST_ARMED;
                            eventCount <= 8'd0;
                            dataValid  <= 1'b0;
                        end
                    end
                end

                default: state <= ST_ARMED;
            endcase
        end
    end

endmodule

// File: tb/tb_event_accumulator.sv
// tb_event_accumulator
// Table of record scenarios plus hand-written reset sequences. Expected drain
// words are queued when a record's final event is driven and popped by a
// monitor on every handshake transfer. A second instance with ACC_W=10 covers
// the overflow behaviour. Build with EVENT_ACC_SATURATE_EN for the
// saturating variant.
`timescale 1ns/1ps

module tb_event_accumulator;

    localparam int DEPTH = 128;
`ifdef EVENT_ACC_SATURATE_EN
    localparam int OVF_WORD = 'h3FF;
`else
    localparam int OVF_WORD = 'h3F8;
`endif

    typedef struct {
        int sel;        // 0: 16-bit instance, 1: 10-bit instance
        int n;          // numEventsToAdd
        bit ramp;       // sample = address, else constant data
        int data;
        int shift;
        bit toggle;     // readyToTransmit toggles every cycle
        int drop_mode;  // 0 none, 1 one strobe mid-capture, 2 strobe on every sample
        int word0;      // expected word at address 0
        int step;       // expected increment per address
        int exp_count;
        bit exp_ovf;
    } rec_t;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        strobe;
    logic [7:0]  num_events;
    logic [3:0]  avg_shift;
    logic        ready;

    logic [15:0] main_dout;
    logic        main_valid, main_busy, main_ovf;
    logic [7:0]  main_cnt, main_drop;
    logic [9:0]  ovf_dout;
    logic        ovf_valid, ovf_busy, ovf_ovf;
    logic [7:0]  ovf_cnt, ovf_drop;

    int          total = 0;
    int          bad = 0;
    int          exp_dropped = 0;
    int          mon_sel = 0;
    bit          ready_toggle = 0;
    int          sb[$];
    bit          stall_prev = 0;
    logic [31:0] held = 0;

    logic [31:0] sel_dout;
    logic        sel_valid, sel_busy, sel_ovf;
    logic [7:0]  sel_cnt, sel_drop;

    assign sel_dout  = (mon_sel != 0) ? 32'(ovf_dout) : 32'(main_dout);
    assign sel_valid = (mon_sel != 0) ? ovf_valid : main_valid;
    assign sel_busy  = (mon_sel != 0) ? ovf_busy  : main_busy;
    assign sel_ovf   = (mon_sel != 0) ? ovf_ovf   : main_ovf;
    assign sel_cnt   = (mon_sel != 0) ? ovf_cnt   : main_cnt;
    assign sel_drop  = (mon_sel != 0) ? ovf_drop  : main_drop;

    event_accumulator #(.DATA_W(8), .ACC_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .inputData(in_data), .dataCaptureStrobe(strobe),
        .numEventsToAdd(num_events), .avgShift(avg_shift), .readyToTransmit(ready),
        .dataOut(main_dout), .dataValid(main_valid), .busy(main_busy),
        .eventCount(main_cnt), .overflow(main_ovf), .droppedTrig(main_drop)
    );

    event_accumulator #(.DATA_W(8), .ACC_W(10), .DEPTH(DEPTH)) dut_ovf (
        .clk(clk), .rst(rst), .inputData(in_data), .dataCaptureStrobe(strobe),
        .numEventsToAdd(num_events), .avgShift(avg_shift), .readyToTransmit(ready),
        .dataOut(ovf_dout), .dataValid(ovf_valid), .busy(ovf_busy),
        .eventCount(ovf_cnt), .overflow(ovf_ovf), .droppedTrig(ovf_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready: steady high or toggling every cycle.
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_toggle) ready = ~ready;
            else              ready = 1'b1;
        end
    end

    // Scoreboard monitor: pops one expectation per transfer, checks stalls hold.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid_held", sel_valid, 1);
                    check("stall_data_stable", sel_dout, held);
                end
                if (sel_valid && ready) begin
                    check("word_expected", sb.size() > 0, 1);
                    if (sb.size() > 0) check("drained_word", sel_dout, sb.pop_front());
                end
                stall_prev = sel_valid && !ready;
                held       = sel_dout;
            end
        end
    end

    task automatic drive_event(input rec_t r, input bit last, input bit first_ev);
        @(posedge clk);
        #1;
        strobe     = 1'b1;
        num_events = 8'(r.n);
        avg_shift  = 4'(r.shift);
        if (last) begin
            for (int a = 0; a < DEPTH; a++) begin
                sb.push_back((r.word0 + a * r.step) & ((r.sel != 0) ? 'h3FF : 'hFFFF));
            end
        end
        for (int a = 0; a < DEPTH; a++) begin
            @(posedge clk);
            #1;
            in_data = r.ramp ? 8'(a) : 8'(r.data);
            strobe  = (r.drop_mode == 2) || (r.drop_mode == 1 && a == 50 && first_ev);
            if (strobe && exp_dropped < 255) exp_dropped++;
        end
        @(posedge clk);
        #1;
        strobe  = 1'b0;
        in_data = 8'd0;
    endtask

    task automatic run_record(input rec_t r, input string tag);
        int n_eff;
        int waited;
        n_eff        = (r.n == 0) ? 1 : r.n;
        mon_sel      = r.sel;
        ready_toggle = r.toggle;
        for (int e = 0; e < n_eff; e++) drive_event(r, e == n_eff - 1, e == 0);
        waited = 0;
        while (!sel_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " first_valid"}, sel_valid, 1);
        check({tag, " valid_latency"}, waited <= 3, 1);
        check({tag, " event_count"}, sel_cnt, r.exp_count);
        check({tag, " overflow"}, sel_ovf, r.exp_ovf);
        check({tag, " dropped"}, sel_drop, exp_dropped);
        for (int i = 0; i < 4 * DEPTH && sb.size() != 0; i++) @(negedge clk);
        check({tag, " drain_done"}, sb.size(), 0);
        for (int i = 0; i < 8 && sel_busy; i++) @(negedge clk);
        check({tag, " idle_busy"}, sel_busy, 0);
        check({tag, " idle_count"}, sel_cnt, 0);
        ready_toggle = 1'b0;
        sb.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " busy"}, main_busy, 0);
        check({tag, " count"}, main_cnt, 0);
        check({tag, " valid"}, main_valid, 0);
        check({tag, " dout"}, main_dout, 0);
        check({tag, " overflow"}, main_ovf, 0);
        check({tag, " dropped"}, main_drop, 0);
        check({tag, " ovf_inst_overflow"}, ovf_ovf, 0);
    endtask

    initial begin
        rec_t tbl[11];
        rec_t r;

        tbl[0]  = '{0, 1, 1, 0,     0,  0, 0, 0,        1, 1, 0};
        tbl[1]  = '{0, 4, 0, 'h10,  0,  0, 0, 'h40,     0, 4, 0};
        tbl[2]  = '{0, 4, 0, 'h10,  2,  0, 0, 'h10,     0, 4, 0};
        tbl[3]  = '{0, 1, 1, 0,     0,  1, 0, 0,        1, 1, 0};
        tbl[4]  = '{0, 1, 1, 0,     0,  0, 1, 0,        1, 1, 0};
        tbl[5]  = '{0, 0, 0, 'h55,  0,  0, 0, 'h55,     0, 1, 0};
        tbl[6]  = '{0, 3, 1, 0,     0,  0, 0, 0,        3, 3, 0};
        tbl[7]  = '{0, 2, 1, 0,     1,  1, 0, 0,        1, 2, 0};
        tbl[8]  = '{0, 2, 0, 'hAA,  0,  0, 2, 'h154,    0, 2, 0};
        tbl[9]  = '{1, 8, 0, 'hFF,  0,  0, 0, OVF_WORD, 0, 8, 1};
        tbl[10] = '{1, 1, 0, 'hFF,  12, 0, 0, 0,        0, 1, 1};

        rst        = 1'b0;
        in_data    = 8'd0;
        strobe     = 1'b0;
        num_events = 8'd1;
        avg_shift  = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_record(tbl[i], $sformatf("rec%0d", i));
        end

        // Reset in the middle of the second event of an N=2 record.
        mon_sel = 0;
        r = '{0, 2, 0, 'h07, 0, 0, 0, 0, 0, 0, 0};
        drive_event(r, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe  = 1'b0;
        in_data = 8'h07;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("rst_cap mid busy", main_busy, 1);
        check("rst_cap mid count", main_cnt, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_dropped = 0;
        @(negedge clk);
        check_reset_state("rst_cap");
        run_record('{0, 2, 0, 'h01, 0, 0, 0, 'h02, 0, 2, 0}, "rst_cap_after");

        // Reset in the middle of a stalled drain.
        mon_sel      = 0;
        ready_toggle = 1'b1;
        r = '{0, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0};
        drive_event(r, 1'b1, 1'b1);
        for (int i = 0; i < 200 && sb.size() > DEPTH - 10; i++) @(negedge clk);
        check("rst_drain progress", sb.size() <= DEPTH - 10, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst          = 1'b1;
        ready_toggle = 1'b0;
        sb.delete();
        @(negedge clk);
        check_reset_state("rst_drain");
        run_record('{0, 1, 0, 'h03, 0, 0, 0, 'h03, 0, 1, 0}, "rst_drain_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
